// File: rtl/des_sbox_layer_pipe.sv
// Purpose: DES substitution layer (S1..S8 in parallel) on a 48-bit word, optional P permutation.
// Latency: PIPE_STAGES cycles (1 or 2); one word per cycle while out_ready stays high.
// Backpressure: a stage advances only when the next one is empty or draining; out_ready->in_ready is the only comb path.
module des_sbox_layer_pipe #(
  parameter int PIPE_STAGES = 1,
  parameter bit APPLY_P     = 1'b1,
  parameter int TAG_W       = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [47:0]      in_data,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
);

  // One S-box entry. Each 64-bit constant is a whole table row, column 0 in the top nibble.
  function automatic logic [3:0] sbox(input logic [2:0] n, input logic [5:0] c);
    logic [63:0] rowv;
    rowv = '0;
    case ({n, c[5], c[0]})
      5'd0:  rowv = 64'hE4D12FB83A6C5907;
      5'd1:  rowv = 64'h0F74E2D1A6CB9538;
      5'd2:  rowv = 64'h41E8D62BFC973A50;
      5'd3:  rowv = 64'hFC8249175B3EA06D;
      5'd4:  rowv = 64'hF18E6B34972DC05A;
      5'd5:  rowv = 64'h3D47F28EC01A69B5;
      5'd6:  rowv = 64'h0E7BA4D158C6932F;
      5'd7:  rowv = 64'hD8A13F42B67C05E9;
      5'd8:  rowv = 64'hA09E63F51DC7B428;
      5'd9:  rowv = 64'hD709346A285ECBF1;
      5'd10: rowv = 64'hD6498F30B12C5AE7;
      5'd11: rowv = 64'h1AD069874FE3B52C;
      5'd12: rowv = 64'h7DE3069A1285BC4F;
      5'd13: rowv = 64'hD8B56F03472C1AE9;
      5'd14: rowv = 64'hA690CB7DF13E5284;
      5'd15: rowv = 64'h3F06A1D8945BC72E;
      5'd16: rowv = 64'h2C417AB6853FD0E9;
      5'd17: rowv = 64'hEB2C47D150FA3986;
      5'd18: rowv = 64'h421BAD78F9C5630E;
      5'd19: rowv = 64'hB8C71E2D6F09A453;
      5'd20: rowv = 64'hC1AF92680D34E75B;
      5'd21: rowv = 64'hAF427C9561DE0B38;
      5'd22: rowv = 64'h9EF528C3704A1DB6;
      5'd23: rowv = 64'h432C95FABE17608D;
      5'd24: rowv = 64'h4B2EF08D3C975A61;
      5'd25: rowv = 64'hD0B7491AE35C2F86;
      5'd26: rowv = 64'h14BDC37EAF680592;
      5'd27: rowv = 64'h6BD814A7950FE23C;
      5'd28: rowv = 64'hD2846FB1A93E50C7;
      5'd29: rowv = 64'h1FD8A374C56B0E92;
      5'd30: rowv = 64'h7B419CE206ADF358;
      5'd31: rowv = 64'h21E74A8DFC90356B;
      default: rowv = '0;
    endcase
    rowv = rowv << {c[4:1], 2'b00};
    return rowv[63:60];
  endfunction

  // All eight boxes: S1 takes the top 6 bits and drives the top nibble.
  function automatic logic [31:0] sbox_layer(input logic [47:0] x);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) begin
      r[31-4*i -: 4] = sbox(3'(i), x[47-6*i -: 6]);
    end
    return r;
  endfunction

  logic [31:0]      s_last;
  logic [TAG_W-1:0] tag_last;

  generate
    if (PIPE_STAGES == 1) begin : g_pipe1
      logic             v1;
      logic [31:0]      d1;
      logic [TAG_W-1:0] t1;

      assign in_ready  = !v1 || out_ready;
      assign out_valid = v1;
      assign busy      = v1;
      assign s_last    = d1;
      assign tag_last  = t1;

      // Single stage: look up on accept, hold while stalled.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          v1 <= 1'b0;
          d1 <= '0;
          t1 <= '0;
        end else if (in_ready) begin
          v1 <= in_valid;
          if (in_valid) begin
            d1 <= sbox_layer(in_data);
            t1 <= in_tag;
          end
        end
      end
    end else if (PIPE_STAGES == 2) begin : g_pipe2
      logic             v1, v2;
      logic             ready1, ready2;
      logic [47:0]      r1;
      logic [TAG_W-1:0] t1, t2;
      logic [31:0]      d2;

      assign ready2    = !v2 || out_ready;
      assign ready1    = !v1 || ready2;
      assign in_ready  = ready1;
      assign out_valid = v2;
      assign busy      = v1 || v2;
      assign s_last    = d2;
      assign tag_last  = t2;

      // Stage 1 captures the raw word; stage 2 captures its lookup. Each moves only when its successor frees up.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          v1 <= 1'b0;
          v2 <= 1'b0;
          r1 <= '0;
          t1 <= '0;
          d2 <= '0;
          t2 <= '0;
        end else begin
          if (ready2) begin
            v2 <= v1;
            if (v1) begin
              d2 <= sbox_layer(r1);
              t2 <= t1;
            end
          end
          if (ready1) begin
            v1 <= in_valid;
            if (in_valid) begin
              r1 <= in_data;
              t1 <= in_tag;
            end
          end
        end
      end
    end else begin : g_bad_stages
      $error("des_sbox_layer_pipe: PIPE_STAGES must be 1 or 2");
    end
  endgenerate

  assign out_tag = tag_last;

  generate
    if (APPLY_P) begin : g_perm
      // DES P: output bit k (1 = MSB) takes S-layer bit P[k]; index here is 32 - P[k].
      assign out_data = {s_last[16], s_last[25], s_last[12], s_last[11],
                         s_last[3],  s_last[20], s_last[4],  s_last[15],
                         s_last[31], s_last[17], s_last[9],  s_last[6],
                         s_last[27], s_last[14], s_last[1],  s_last[22],
                         s_last[30], s_last[24], s_last[8],  s_last[18],
                         s_last[0],  s_last[5],  s_last[29], s_last[23],
                         s_last[13], s_last[19], s_last[2],  s_last[26],
                         s_last[10], s_last[21], s_last[28], s_last[7]};
    end else begin : g_raw
      assign out_data = s_last;
    end
  endgenerate

endmodule

// File: tb/tb_des_sbox_layer_pipe.sv
// Bench for des_sbox_layer_pipe: four instances covering PIPE_STAGES {1,2} x APPLY_P {0,1}.
// Index k: 0 = 1 stage raw, 1 = 2 stages raw, 2 = 1 stage with P, 3 = 2 stages with P.
// Directed vectors plus a table-driven reference for the streaming scenarios.
module tb_des_sbox_layer_pipe;
  localparam int N = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid  [N];
  logic        in_ready  [N];
  logic [47:0] in_data   [N];
  logic [3:0]  in_tag    [N];
  logic        out_valid [N];
  logic        out_ready [N];
  logic [31:0] out_data  [N];
  logic [3:0]  out_tag   [N];
  logic        busy      [N];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  des_sbox_layer_pipe #(.PIPE_STAGES(1), .APPLY_P(1'b0), .TAG_W(4)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_data(in_data[0]),
    .in_tag(in_tag[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_data(out_data[0]),
    .out_tag(out_tag[0]), .busy(busy[0]));
  des_sbox_layer_pipe #(.PIPE_STAGES(2), .APPLY_P(1'b0), .TAG_W(4)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_data(in_data[1]),
    .in_tag(in_tag[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_data(out_data[1]),
    .out_tag(out_tag[1]), .busy(busy[1]));
  des_sbox_layer_pipe #(.PIPE_STAGES(1), .APPLY_P(1'b1), .TAG_W(4)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[2]), .in_ready(in_ready[2]), .in_data(in_data[2]),
    .in_tag(in_tag[2]), .out_valid(out_valid[2]), .out_ready(out_ready[2]), .out_data(out_data[2]),
    .out_tag(out_tag[2]), .busy(busy[2]));
  des_sbox_layer_pipe #(.PIPE_STAGES(2), .APPLY_P(1'b1), .TAG_W(4)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[3]), .in_ready(in_ready[3]), .in_data(in_data[3]),
    .in_tag(in_tag[3]), .out_valid(out_valid[3]), .out_ready(out_ready[3]), .out_data(out_data[3]),
    .out_tag(out_tag[3]), .busy(busy[3]));

  // FIPS 46-3 S-boxes, row-major (row*16 + col).
  int sb [8][64] = '{
    '{14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7, 0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8, 4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0, 15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13},
    '{15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10, 3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5, 0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15, 13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9},
    '{10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8, 13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1, 13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7, 1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12},
    '{7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15, 13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9, 10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4, 3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14},
    '{2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9, 14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6, 4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14, 11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3},
    '{12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11, 10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8, 9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6, 4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13},
    '{4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1, 13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6, 1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2, 6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12},
    '{13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7, 1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2, 7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8, 2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11}
  };
  int p_tab [32] = '{16,7,20,21,29,12,28,17,1,15,23,26,5,18,31,10,2,8,24,14,32,27,3,9,19,13,30,6,22,11,4,25};

  function automatic int stg(input int k);
    return (k == 1 || k == 3) ? 2 : 1;
  endfunction

  function automatic logic [31:0] model(input int k, input logic [47:0] x);
    logic [31:0] s;
    logic [31:0] p;
    logic [5:0]  c;
    int          e;
    s = '0;
    p = '0;
    for (int i = 0; i < 8; i++) begin
      c = x[47-6*i -: 6];
      e = sb[i][{c[5], c[0], c[4:1]}];
      s[31-4*i -: 4] = e[3:0];
    end
    if (k < 2) return s;
    for (int i = 0; i < 32; i++) p[31-i] = s[32-p_tab[i]];
    return p;
  endfunction

  task automatic idle_all();
    for (int k = 0; k < N; k++) begin
      in_valid[k]  = 1'b0;
      in_data[k]   = 48'hA5A5A5A5A5A5;
      in_tag[k]    = 4'hA;
      out_ready[k] = 1'b1;
    end
  endtask

  // Offers one word on an idle instance and reports the cycles until its result shows.
  task automatic send_one(input int k, input logic [47:0] d, input logic [3:0] t,
                          output logic [31:0] got, output logic [3:0] gtag, output int lat);
    got = '0; gtag = '0; lat = -1;
    @(negedge clk);
    in_valid[k] = 1'b1; in_data[k] = d; in_tag[k] = t; out_ready[k] = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      in_valid[k] = 1'b0; in_data[k] = 48'hA5A5A5A5A5A5; in_tag[k] = 4'hA;
      #1;
      if (out_valid[k]) begin
        got = out_data[k]; gtag = out_tag[k]; lat = c;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_all();
    repeat (3) @(negedge clk);
    #1;
    for (int k = 0; k < N; k++) begin
      checks++;
      if (out_valid[k] !== 1'b0 || busy[k] !== 1'b0) begin
        failures++; $display("FAIL reset_valid k=%0d out_valid=%b busy=%b want 0/0", k, out_valid[k], busy[k]);
      end
      checks++;
      if (out_data[k] !== 32'h0 || out_tag[k] !== 4'h0) begin
        failures++; $display("FAIL reset_data k=%0d data=%h tag=%h want 0/0", k, out_data[k], out_tag[k]);
      end
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int k = 0; k < N; k++) begin
      checks++;
      if (in_ready[k] !== 1'b1) begin
        failures++; $display("FAIL reset_in_ready k=%0d got=%b want 1", k, in_ready[k]);
      end
    end
  endtask

  task automatic test_known_vectors();
    logic [31:0] got;
    logic [3:0]  gtag;
    logic [31:0] exp;
    int          lat;
    for (int k = 0; k < N; k++) begin
      send_one(k, 48'h0, 4'd3, got, gtag, lat);
      exp = (k >= 2) ? 32'hD8D8DBBC : 32'hEFA72C4D;
      checks++;
      if (lat != stg(k)) begin
        failures++; $display("FAIL zero_latency k=%0d got=%0d want %0d", k, lat, stg(k));
      end
      checks++;
      if (got !== exp || gtag !== 4'd3) begin
        failures++; $display("FAIL zero_vector k=%0d data=%h tag=%0d want %h/3", k, got, gtag, exp);
      end
      send_one(k, 48'hFFFFFFFFFFFF, 4'd9, got, gtag, lat);
      exp = (k >= 2) ? model(k, 48'hFFFFFFFFFFFF) : 32'hD9CE3DCB;
      checks++;
      if (got !== exp || gtag !== 4'd9) begin
        failures++; $display("FAIL ones_vector k=%0d data=%h tag=%0d want %h/9", k, got, gtag, exp);
      end
    end
  endtask

  task automatic test_s8_addr();
    logic [5:0]  ch  [4] = '{6'b100000, 6'b000001, 6'b011110, 6'b011100};
    logic [3:0]  nib [4] = '{4'd7, 4'd1, 4'd7, 4'd12};
    logic [31:0] got;
    logic [3:0]  gtag;
    int          lat;
    for (int i = 0; i < 4; i++) begin
      send_one(0, {42'h0, ch[i]}, 4'(i), got, gtag, lat);
      checks++;
      if (got !== {28'hEFA72C4, nib[i]}) begin
        failures++; $display("FAIL s8_addr chunk=%b got=%h want %h", ch[i], got, {28'hEFA72C4, nib[i]});
      end
    end
  endtask

  task automatic test_back_to_back(input int k);
    logic [47:0] wd [64];
    logic [3:0]  wt [64];
    int sent = 0, recv = 0, first = -1;
    for (int i = 0; i < 64; i++) begin
      wd[i] = {16'($urandom), 32'($urandom)};
      wt[i] = 4'(i);
    end
    for (int cyc = 0; cyc < 80 && recv < 64; cyc++) begin
      @(negedge clk);
      out_ready[k] = 1'b1;
      if (sent < 64) begin
        in_valid[k] = 1'b1; in_data[k] = wd[sent]; in_tag[k] = wt[sent];
      end else begin
        in_valid[k] = 1'b0; in_data[k] = 48'hA5A5A5A5A5A5;
      end
      #1;
      if (in_valid[k]) begin
        checks++;
        if (!in_ready[k]) begin
          failures++; $display("FAIL b2b_in_ready k=%0d cyc=%0d got=0 want 1", k, cyc);
        end
      end
      if (in_valid[k] && in_ready[k]) sent++;
      if (out_valid[k]) begin
        if (first < 0) first = cyc;
        checks++;
        if (out_data[k] !== model(k, wd[recv]) || out_tag[k] !== wt[recv]) begin
          failures++;
          $display("FAIL b2b_data k=%0d idx=%0d got=%h/%0d want %h/%0d", k, recv, out_data[k], out_tag[k], model(k, wd[recv]), wt[recv]);
        end
        recv++;
      end else if (first >= 0) begin
        checks++; failures++;
        $display("FAIL b2b_bubble k=%0d cyc=%0d out_valid=0 want 1", k, cyc);
      end
    end
    in_valid[k] = 1'b0;
    checks++;
    if (first != stg(k)) begin
      failures++; $display("FAIL b2b_latency k=%0d got=%0d want %0d", k, first, stg(k));
    end
    checks++;
    if (recv != 64) begin
      failures++; $display("FAIL b2b_count k=%0d got=%0d want 64", k, recv);
    end
  endtask

  task automatic test_random_stall(input int k);
    logic [31:0] q_d [$];
    logic [3:0]  q_t [$];
    logic [47:0] cur_d = '0;
    logic [3:0]  cur_t = '0;
    logic [31:0] hd = '0;
    logic [3:0]  ht = '0;
    bit offer = 0, held = 0, exp_rdy;
    int sent = 0, recv = 0, occ = 0;
    for (int cyc = 0; cyc < 3000 && recv < 80; cyc++) begin
      @(negedge clk);
      if (!offer && sent < 80 && $urandom_range(0, 2) != 0) begin
        offer = 1; cur_d = {16'($urandom), 32'($urandom)}; cur_t = 4'(sent);
      end
      in_valid[k] = offer;
      in_data[k]  = offer ? cur_d : 48'hA5A5A5A5A5A5;
      in_tag[k]   = offer ? cur_t : 4'hA;
      out_ready[k] = 1'($urandom_range(0, 1));
      #1;
      exp_rdy = !(occ == stg(k) && !out_ready[k]);
      checks++;
      if (in_ready[k] !== exp_rdy) begin
        failures++; $display("FAIL stall_in_ready k=%0d cyc=%0d got=%b want %b", k, cyc, in_ready[k], exp_rdy);
      end
      checks++;
      if (busy[k] !== (occ > 0)) begin
        failures++; $display("FAIL stall_busy k=%0d cyc=%0d got=%b want %b", k, cyc, busy[k], occ > 0);
      end
      if (held) begin
        checks++;
        if (out_valid[k] !== 1'b1 || out_data[k] !== hd || out_tag[k] !== ht) begin
          failures++; $display("FAIL stall_hold k=%0d cyc=%0d got=%b/%h/%0d want 1/%h/%0d", k, cyc, out_valid[k], out_data[k], out_tag[k], hd, ht);
        end
      end
      if (out_valid[k] && out_ready[k]) begin
        checks++;
        if (q_d.size() == 0) begin
          failures++; $display("FAIL stall_extra k=%0d cyc=%0d got=%h want none", k, cyc, out_data[k]);
        end else begin
          if (out_data[k] !== q_d[0] || out_tag[k] !== q_t[0]) begin
            failures++; $display("FAIL stall_data k=%0d idx=%0d got=%h/%0d want %h/%0d", k, recv, out_data[k], out_tag[k], q_d[0], q_t[0]);
          end
          void'(q_d.pop_front());
          void'(q_t.pop_front());
        end
        recv++; occ--;
      end
      held = out_valid[k] && !out_ready[k];
      hd = out_data[k];
      ht = out_tag[k];
      if (offer && in_ready[k]) begin
        q_d.push_back(model(k, cur_d));
        q_t.push_back(cur_t);
        sent++; occ++; offer = 0;
      end
    end
    in_valid[k] = 1'b0;
    out_ready[k] = 1'b1;
    checks++;
    if (recv != 80 || q_d.size() != 0) begin
      failures++; $display("FAIL stall_count k=%0d got=%0d left=%0d want 80/0", k, recv, q_d.size());
    end
  endtask

  task automatic test_reset_inflight();
    logic [31:0] got;
    logic [3:0]  gtag;
    logic [31:0] exp;
    int          lat;
    @(negedge clk);
    for (int k = 0; k < N; k++) begin
      in_valid[k] = 1'b1; in_data[k] = 48'h123456789ABC; in_tag[k] = 4'd1; out_ready[k] = 1'b0;
    end
    @(negedge clk);
    for (int k = 0; k < N; k++) begin
      in_data[k] = 48'hFEDCBA987654; in_tag[k] = 4'd2;
    end
    @(negedge clk);
    for (int k = 0; k < N; k++) in_valid[k] = 1'b0;
    #1;
    for (int k = 0; k < N; k++) begin
      checks++;
      if (busy[k] !== 1'b1) begin
        failures++; $display("FAIL inflight_busy k=%0d got=%b want 1", k, busy[k]);
      end
    end
    #2 rst_n = 1'b0;
    #1;
    for (int k = 0; k < N; k++) begin
      checks++;
      if (out_valid[k] !== 1'b0 || busy[k] !== 1'b0) begin
        failures++; $display("FAIL async_reset k=%0d out_valid=%b busy=%b want 0/0", k, out_valid[k], busy[k]);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < N; k++) out_ready[k] = 1'b1;
    @(posedge clk);
    #1;
    for (int k = 0; k < N; k++) begin
      checks++;
      if (out_valid[k] !== 1'b0 || in_ready[k] !== 1'b1) begin
        failures++; $display("FAIL post_reset k=%0d out_valid=%b in_ready=%b want 0/1", k, out_valid[k], in_ready[k]);
      end
    end
    for (int k = 0; k < N; k++) begin
      send_one(k, 48'h0, 4'd5, got, gtag, lat);
      exp = (k >= 2) ? 32'hD8D8DBBC : 32'hEFA72C4D;
      checks++;
      if (lat != stg(k) || got !== exp || gtag !== 4'd5) begin
        failures++; $display("FAIL post_reset_word k=%0d lat=%0d data=%h tag=%0d want %0d/%h/5", k, lat, got, gtag, stg(k), exp);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    idle_all();
    test_reset();
    test_known_vectors();
    test_s8_addr();
    for (int k = 0; k < N; k++) test_back_to_back(k);
    for (int k = 0; k < N; k++) test_random_stall(k);
    test_reset_inflight();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
